uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 42 ++++
 rtl/uart_rx.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial line, the per-frame configuration and the receive results
// of the UART receiver into one port.
//   slave  : receiver side (takes rx_in/prescale/par_en/par_typ, returns the
//            results).
//   master : line driver / consumer side.
// Signals:
//   rx_in       serial line, idle high, already synchronous to clk
//   prescale    clocks per bit (even, 8..32)
//   par_en      1 = frame carries a parity bit
//   par_typ     0 = even parity, 1 = odd parity
//   data_out    last correctly received word
//   data_valid  one-cycle pulse, frame passed all checks
//   par_err     one-cycle pulse, parity check failed
//   stp_err     one-cycle pulse, stop bit sampled low
//   busy        high while a frame is in progress
// -----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  rx_in;
    logic [PRESCALE_W-1:0] prescale;
    logic                  par_en;
    logic                  par_typ;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport slave (
        input  rx_in, prescale, par_en, par_typ,
        output data_out, data_valid, par_err, stp_err, busy
    );

    modport master (
        output rx_in, prescale, par_en, par_typ,
        input  data_out, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver. Each bit lasts P clocks (P = prescale latched at
// the start bit); the line is sampled at edge counts P/2-1, P/2, P/2+1 and the
// bit value is the 2-of-3 majority. Frame: start(0), DATA_WIDTH data bits LSB
// first, optional parity, one stop bit(1).
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      uart_rx_if.slave (line, configuration, results, busy)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic      clk,
    input  logic      reset_n,
    uart_rx_if.slave  bus
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] P_MAX = PRESCALE_W'(32);
    localparam logic [BW-1:0]         B_ONE = BW'(1);
    localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   armed_q, armed_d;
    logic [PRESCALE_W-1:0]  edge_q, edge_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_W-1:0]  presc_q, presc_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   par_fail_q, par_fail_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   par_err_q, par_err_d;
    logic                   stp_err_q, stp_err_d;
    logic                   busy_w;

    // Bit-timing decodes relative to the latched prescale.
    logic [PRESCALE_W-1:0]  mid;
    logic                   at_s0, at_s1, at_dec, at_end;
    logic                   maj;
    logic                   start_det;
    logic                   stop_dec;
    logic [PRESCALE_W-1:0]  presc_clamp;

    assign mid    = presc_q >> 1;
    assign at_s0  = (edge_q == mid - P_ONE);
    assign at_s1  = (edge_q == mid);
    assign at_dec = (edge_q == mid + P_ONE);
    assign at_end = (edge_q == presc_q - P_ONE);

    // Third vote is the live line value at edge P/2+1; the decision is
    // registered on that edge, so it becomes visible the cycle after.
    assign maj = (samp_q[0] & samp_q[1]) |
                 (samp_q[0] & bus.rx_in) |
                 (samp_q[1] & bus.rx_in);

    assign start_det = (state_q == S_IDLE) && armed_q && !bus.rx_in;
    assign stop_dec  = (state_q == S_STOP) && at_dec;

    // Out-of-range prescale values are pulled into 8..32 so a frame can never
    // outlast 11 bits of 32 clocks.
    assign presc_clamp = (bus.prescale < P_MIN) ? P_MIN :
                         (bus.prescale > P_MAX) ? P_MAX : bus.prescale;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_det) state_d = S_START;
            end
            S_START: begin
                // A high majority means the falling edge was a glitch.
                if (at_dec && maj)  state_d = S_IDLE;
                else if (at_end)    state_d = S_DATA;
            end
            S_DATA: begin
                if (at_end && (bit_cnt_q == LAST_BIT))
                    state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Leave mid stop bit; the rest of it re-arms IDLE.
                if (at_dec) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        busy_w       = (state_q != S_IDLE);
        if (stop_dec) begin
            if (!maj)            stp_err_d    = 1'b1;
            else if (par_fail_q) par_err_d    = 1'b1;
            else                 data_valid_d = 1'b1;
        end
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        armed_d    = armed_q;
        edge_d     = edge_q;
        bit_cnt_d  = bit_cnt_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        samp_d     = samp_q;
        par_fail_d = par_fail_q;
        data_out_d = data_out_q;

        if (start_det || stop_dec)
            armed_d = 1'b0;
        else if ((state_q == S_IDLE) && bus.rx_in)
            armed_d = 1'b1;

        // The detecting cycle is edge 0, so the counter enters START at 1.
        if (state_d == S_IDLE)  edge_d = '0;
        else if (start_det)     edge_d = P_ONE;
        else if (at_end)        edge_d = '0;
        else                    edge_d = edge_q + P_ONE;

        if (state_q != S_DATA)  bit_cnt_d = '0;
        else if (at_end)        bit_cnt_d = bit_cnt_q + B_ONE;

        if (start_det) begin
            presc_d    = presc_clamp;
            par_en_d   = bus.par_en;
            par_typ_d  = bus.par_typ;
            par_fail_d = 1'b0;
        end

        if (state_q != S_IDLE) begin
            if (at_s0) samp_d[0] = bus.rx_in;
            if (at_s1) samp_d[1] = bus.rx_in;
        end

        if ((state_q == S_PARITY) && at_dec)
            par_fail_d = (maj != ((^shift_q) ^ par_typ_q));

        if (data_valid_d)
            data_out_d = shift_q;
    end

    // Each data bit lands directly in its own position of the shift register.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift
        assign shift_d[gi] = ((state_q == S_DATA) && at_dec && (bit_cnt_q == BW'(gi)))
                             ? maj : shift_q[gi];
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q      <= 1'b0;
            edge_q       <= '0;
            bit_cnt_q    <= '0;
            presc_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_fail_q   <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            armed_q      <= armed_d;
            edge_q       <= edge_d;
            bit_cnt_q    <= bit_cnt_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_fail_q   <= par_fail_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.busy       = busy_w;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed frames against uart_rx with hand-computed expectations. Inputs are
// driven 1 time unit after the rising edge; a negedge monitor counts output
// pulses and records when data_valid fired.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int dv_cnt       = 0;
    int pe_cnt       = 0;
    int se_cnt       = 0;
    int dv_cyc       = 0;
    logic dv_busy    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid) begin
            dv_cnt  = dv_cnt + 1;
            dv_cyc  = cyc;
            dv_busy = bus.busy;
        end
        if (bus.par_err) pe_cnt = pe_cnt + 1;
        if (bus.stp_err) se_cnt = se_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        dv_cnt = 0;
        pe_cnt = 0;
        se_cnt = 0;
    endtask

    // One bit of p clocks; optional one-cycle inversion at edge p/2.
    task automatic drive_bit(input logic v, input int p, input bit glitch);
        for (int j = 0; j < p; j++) begin
            bus.rx_in = (glitch && (j == p / 2)) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit with_par,
                              input logic par_bit, input logic stop_bit, input bit glitch,
                              output int c0);
        c0 = cyc;
        $display("[TB] frame 0x%02h P=%0d par_en=%0d par_bit=%0d stop=%0d glitch=%0d",
                 d, p, with_par, par_bit, stop_bit, glitch);
        drive_bit(1'b0, p, 1'b0);
        for (int k = 0; k < 8; k++) drive_bit(d[k], p, glitch);
        if (with_par) drive_bit(par_bit, p, 1'b0);
        drive_bit(stop_bit, p, 1'b0);
    endtask

    initial begin
        int c0;
        bus.rx_in    = 1'b1;
        bus.prescale = 6'd8;
        bus.par_en   = 1'b0;
        bus.par_typ  = 1'b0;
        reset_n      = 1'b0;
        tick(3);

        // Reset state
        check_eq("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
        check_eq("rst_par_err",    {31'd0, bus.par_err},    32'd0);
        check_eq("rst_stp_err",    {31'd0, bus.stp_err},    32'd0);
        check_eq("rst_busy",       {31'd0, bus.busy},       32'd0);
        check_eq("rst_data_out",   {24'd0, bus.data_out},   32'd0);
        reset_n = 1'b1;
        tick(3);

        // P=8, no parity, 0xA5: pulse at cycle 78, busy already low then
        clear_counts();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        check_eq("a5_dv_cnt",   dv_cnt, 1);
        check_eq("a5_pe_cnt",   pe_cnt, 0);
        check_eq("a5_se_cnt",   se_cnt, 0);
        check_eq("a5_data",     {24'd0, bus.data_out}, 32'hA5);
        check_eq("a5_dv_cycle", dv_cyc - c0, 78);
        check_eq("a5_dv_busy",  {31'd0, dv_busy}, 32'd0);
        tick(4);

        // P=16, even parity: 0x3C has four ones, so parity bit 0 is correct
        bus.prescale = 6'd16;
        bus.par_en   = 1'b1;
        bus.par_typ  = 1'b0;
        clear_counts();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, c0);
        check_eq("par_ok_dv",   dv_cnt, 1);
        check_eq("par_ok_pe",   pe_cnt, 0);
        check_eq("par_ok_data", {24'd0, bus.data_out}, 32'h3C);
        tick(4);
        clear_counts();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0, c0);
        check_eq("par_bad_pe",   pe_cnt, 1);
        check_eq("par_bad_dv",   dv_cnt, 0);
        check_eq("par_bad_se",   se_cnt, 0);
        check_eq("par_bad_data", {24'd0, bus.data_out}, 32'h3C);
        tick(4);
        // Odd parity: the correct parity bit for 0x3C becomes 1
        bus.par_typ = 1'b1;
        clear_counts();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0, c0);
        check_eq("par_odd_dv", dv_cnt, 1);
        check_eq("par_odd_pe", pe_cnt, 0);
        tick(4);

        // P=8, stop bit 0 -> stp_err only; line stays low, no new start
        bus.prescale = 6'd8;
        bus.par_en   = 1'b0;
        bus.par_typ  = 1'b0;
        clear_counts();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, c0);
        check_eq("stp_se",   se_cnt, 1);
        check_eq("stp_dv",   dv_cnt, 0);
        check_eq("stp_pe",   pe_cnt, 0);
        check_eq("stp_data", {24'd0, bus.data_out}, 32'h3C);
        tick(20);
        check_eq("stp_low_busy", {31'd0, bus.busy}, 32'd0);
        bus.rx_in = 1'b1;
        tick(8);
        clear_counts();
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        check_eq("rearm_dv",   dv_cnt, 1);
        check_eq("rearm_se",   se_cnt, 0);
        check_eq("rearm_data", {24'd0, bus.data_out}, 32'h12);
        tick(4);

        // Start-bit glitch: low for 2 cycles only
        clear_counts();
        $display("[TB] start glitch P=8, 2 low cycles");
        bus.rx_in = 1'b0;
        tick(2);
        bus.rx_in = 1'b1;
        tick(2);
        check_eq("glitch_busy_hi", {31'd0, bus.busy}, 32'd1);
        tick(3);
        check_eq("glitch_busy_lo", {31'd0, bus.busy}, 32'd0);
        tick(5);
        check_eq("glitch_pulses", dv_cnt + pe_cnt + se_cnt, 0);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        check_eq("ff_dv",   dv_cnt, 1);
        check_eq("ff_data", {24'd0, bus.data_out}, 32'hFF);
        tick(4);

        // P=32, back-to-back 0x81 with mid-bit glitches
        bus.prescale = 6'd32;
        clear_counts();
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b1, 1'b1, c0);
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b1, 1'b1, c0);
        check_eq("b2b_dv",   dv_cnt, 2);
        check_eq("b2b_err",  pe_cnt + se_cnt, 0);
        check_eq("b2b_data", {24'd0, bus.data_out}, 32'h81);
        tick(4);

        // Reset during data bit 4 of 0x0F
        bus.prescale = 6'd8;
        clear_counts();
        $display("[TB] reset during bit 4 of 0x0F");
        drive_bit(1'b0, 8, 1'b0);
        for (int k = 0; k < 4; k++) drive_bit(1'b1, 8, 1'b0);
        bus.rx_in = 1'b0;
        tick(4);
        check_eq("mid_busy", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        tick(2);
        check_eq("mrst_busy",     {31'd0, bus.busy},       32'd0);
        check_eq("mrst_data_out", {24'd0, bus.data_out},   32'd0);
        check_eq("mrst_outs",     {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
        reset_n = 1'b1;
        tick(10);
        check_eq("mrst_low_busy", {31'd0, bus.busy}, 32'd0);
        bus.rx_in = 1'b1;
        tick(8);
        check_eq("mrst_pulses", dv_cnt + pe_cnt + se_cnt, 0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 1'b0, c0);
        check_eq("0f_dv",   dv_cnt, 1);
        check_eq("0f_data", {24'd0, bus.data_out}, 32'h0F);
        tick(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
